// File: rtl/hack_prog_loader.sv
// hack_prog_loader: streams a program into instruction memory while holding the CPU in reset,
// then hands the ROM address over to the CPU program counter. Optional: LOADER_CHECKSUM_EN.
module hack_prog_loader #(
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 32768,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] rom_wdata,
  output logic              rom_we,
  output logic              cpu_rst,
  output logic              busy,
  output logic [ADDR_W:0]   word_count,
  output logic              ovf_err,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

  state_t            state;
  logic              finishing;
  logic [ADDR_W-1:0] wr_ptr;
  logic              full;
  logic              accept;

  // finishing marks the cycle in which the final word is being written, before RUN
  assign full     = (word_count >= DEPTH_C);
  assign in_ready = (state == LOAD) && !finishing && !full;
  assign busy     = (state == LOAD);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      finishing  <= 1'b0;
      cpu_rst    <= 1'b1;
      rom_we     <= 1'b0;
      rom_addr   <= BASE_C;
      rom_wdata  <= '0;
      wr_ptr     <= BASE_C;
      word_count <= '0;
      ovf_err    <= 1'b0;
    end else begin
      rom_we <= 1'b0;
      if (load_start) begin
        state      <= LOAD;
        finishing  <= 1'b0;
        cpu_rst    <= 1'b1;
        wr_ptr     <= BASE_C;
        word_count <= '0;
        ovf_err    <= 1'b0;
      end else begin
        case (state)
          IDLE: cpu_rst <= 1'b1;
          LOAD: begin
            if (finishing) begin
              state     <= RUN;
              finishing <= 1'b0;
              cpu_rst   <= 1'b0;
            end else if (accept) begin
              rom_we     <= 1'b1;
              rom_addr   <= wr_ptr;
              rom_wdata  <= in_data;
              wr_ptr     <= wr_ptr + 1'b1;
              word_count <= word_count + 1'b1;
              finishing  <= in_last;
            end else if (in_valid && full) begin
              // memory full: word is dropped, but a last marker still ends the load
              ovf_err <= 1'b1;
              if (in_last) begin
                state   <= RUN;
                cpu_rst <= 1'b0;
              end
            end
          end
          RUN: begin
            cpu_rst  <= 1'b0;
            rom_addr <= pc;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || load_start) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= checksum + in_data;
    end
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_hack_prog_loader.sv
// tb_hack_prog_loader: directed plus randomized loads compared every cycle against a
// transaction-level model of the loader (small DEPTH so the full/overflow path is reachable).
module tb_hack_prog_loader;

  localparam int ADDR_W    = 15;
  localparam int DATA_W    = 16;
  localparam int DEPTH     = 4;
  localparam int BASE_ADDR = 0;

  localparam int M_IDLE     = 0;
  localparam int M_LOADING  = 1;
  localparam int M_DRAINING = 2;
  localparam int M_RUN      = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_wdata;
  logic              rom_we;
  logic              cpu_rst;
  logic              busy;
  logic [ADDR_W:0]   word_count;
  logic              ovf_err;
  logic [DATA_W-1:0] checksum;

  hack_prog_loader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)
  ) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready), .pc(pc),
    .rom_addr(rom_addr), .rom_wdata(rom_wdata), .rom_we(rom_we), .cpu_rst(cpu_rst),
    .busy(busy), .word_count(word_count), .ovf_err(ovf_err), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Transaction-level model: load progress as counters, expected writes, memory image
  int                mPhase = M_IDLE;
  int                mCount = 0;
  bit                mOvf = 1'b0;
  bit                mReady;
  bit                mWe = 1'b0;
  bit                mAddrKnown = 1'b0;
  bit                modelValid = 1'b0;
  logic [DATA_W-1:0] mSum = '0;
  logic [DATA_W-1:0] mWdata = '0;
  logic [ADDR_W-1:0] mPtr = '0;
  logic [ADDR_W-1:0] mRomAddr = '0;
  logic [DATA_W-1:0] dutMem [8];

  always @(posedge clk) begin
    if (rst) begin
      mPhase = M_IDLE; mCount = 0; mOvf = 0; mSum = '0; mWe = 0;
      mPtr = ADDR_W'(BASE_ADDR); mRomAddr = ADDR_W'(BASE_ADDR); mWdata = '0;
      mAddrKnown = 1; modelValid = 1;
    end else begin
      mReady = (mPhase == M_LOADING) && (mCount < DEPTH);
      mWe = 0;
      if (load_start) begin
        mPhase = M_LOADING; mCount = 0; mOvf = 0; mSum = '0;
        mPtr = ADDR_W'(BASE_ADDR); mAddrKnown = 0;
      end else if (mPhase == M_RUN) begin
        mRomAddr = pc; mAddrKnown = 1;
      end else if (mPhase == M_DRAINING) begin
        mPhase = M_RUN; mAddrKnown = 0;
      end else if (mPhase == M_LOADING && in_valid) begin
        if (mReady) begin
          mWe = 1; mRomAddr = mPtr; mWdata = in_data; mAddrKnown = 1;
          mPtr = mPtr + 1'b1; mCount++; mSum = mSum + in_data;
          if (in_last) mPhase = M_DRAINING;
        end else begin
          mOvf = 1;
          if (in_last) begin mPhase = M_RUN; mAddrKnown = 0; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("cpu_rst", 32'(cpu_rst), 32'(mPhase != M_RUN));
      checkOutput("busy", 32'(busy), 32'(mPhase == M_LOADING || mPhase == M_DRAINING));
      checkOutput("in_ready", 32'(in_ready), 32'(mPhase == M_LOADING && mCount < DEPTH));
      checkOutput("rom_we", 32'(rom_we), 32'(mWe));
      checkOutput("rom_wdata", 32'(rom_wdata), 32'(mWdata));
      checkOutput("word_count", 32'(word_count), 32'(mCount));
      checkOutput("ovf_err", 32'(ovf_err), 32'(mOvf));
`ifdef LOADER_CHECKSUM_EN
      checkOutput("checksum", 32'(checksum), 32'(mSum));
`else
      checkOutput("checksum", 32'(checksum), 32'h0);
`endif
      if (mAddrKnown) checkOutput("rom_addr", 32'(rom_addr), 32'(mRomAddr));
      if (rom_we === 1'b1) dutMem[rom_addr[2:0]] = rom_wdata;
    end
  end

  task automatic applyStimulus(input bit ls, input bit v, input bit lst,
                               input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] p);
    load_start = ls; in_valid = v; in_last = lst; in_data = d; pc = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int sent;
    bit v;
    bit ls;
    rst = 1; load_start = 0; in_valid = 0; in_last = 0; in_data = '0; pc = '0;
    for (int i = 0; i < 8; i++) dutMem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset cpu_rst", 32'(cpu_rst), 32'd1);
    checkOutput("reset in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset rom_we", 32'(rom_we), 32'd0);
    checkOutput("reset rom_addr", 32'(rom_addr), 32'd0);
    checkOutput("reset word_count", 32'(word_count), 32'd0);
    rst = 0;
    applyStimulus(0, 0, 0, '0, '0);

    // basic three-word load
    applyStimulus(1, 0, 0, '0, '0);
    applyStimulus(0, 1, 0, 16'h1111, '0);
    applyStimulus(0, 1, 0, 16'h2222, '0);
    applyStimulus(0, 1, 1, 16'h3333, '0);
    checkOutput("basic last write addr", 32'(rom_addr), 32'd2);
    checkOutput("basic last write data", 32'(rom_wdata), 32'h3333);
    applyStimulus(0, 0, 0, '0, '0);
    applyStimulus(0, 0, 0, '0, '0);
    checkOutput("basic cpu_rst released", 32'(cpu_rst), 32'd0);
    checkOutput("basic word_count", 32'(word_count), 32'd3);
    checkOutput("basic mem0", 32'(dutMem[0]), 32'h1111);
    checkOutput("basic mem1", 32'(dutMem[1]), 32'h2222);
`ifdef LOADER_CHECKSUM_EN
    checkOutput("basic checksum", 32'(checksum), 32'h6666);
`else
    checkOutput("basic checksum", 32'(checksum), 32'h0);
`endif

    // run-mode address tracking
    applyStimulus(0, 0, 0, '0, 15'h0005);
    checkOutput("run rom_addr 0005", 32'(rom_addr), 32'h0005);
    applyStimulus(0, 0, 0, '0, 15'h7FFF);
    checkOutput("run rom_addr 7FFF", 32'(rom_addr), 32'h7FFF);

    // backpressure gaps, exactly DEPTH words
    applyStimulus(1, 0, 0, '0, '0);
    applyStimulus(0, 1, 0, 16'hE001, '0);
    applyStimulus(0, 0, 0, 16'hDEAD, '0);
    applyStimulus(0, 1, 0, 16'hE002, '0);
    applyStimulus(0, 0, 0, 16'hDEAD, '0);
    applyStimulus(0, 1, 0, 16'hE003, '0);
    applyStimulus(0, 0, 0, 16'hDEAD, '0);
    applyStimulus(0, 1, 1, 16'hE004, '0);
    applyStimulus(0, 0, 0, '0, '0);
    applyStimulus(0, 0, 0, '0, '0);
    checkOutput("gaps word_count", 32'(word_count), 32'd4);
    checkOutput("gaps mem1", 32'(dutMem[1]), 32'hE002);
    checkOutput("gaps mem3", 32'(dutMem[3]), 32'hE004);
    checkOutput("gaps ovf_err", 32'(ovf_err), 32'd0);

    // overflow: six words into a four-word memory
    applyStimulus(1, 0, 0, '0, '0);
    for (int i = 1; i <= 4; i++) applyStimulus(0, 1, 0, 16'hA000 + 16'(i), '0);
    checkOutput("full in_ready", 32'(in_ready), 32'd0);
    applyStimulus(0, 1, 0, 16'hA005, '0);
    applyStimulus(0, 1, 1, 16'hA006, '0);
    checkOutput("ovf ovf_err", 32'(ovf_err), 32'd1);
    checkOutput("ovf cpu_rst", 32'(cpu_rst), 32'd0);
    checkOutput("ovf word_count", 32'(word_count), 32'd4);
    checkOutput("ovf mem3", 32'(dutMem[3]), 32'hA004);

    // restart from RUN, then mid-load with a same-cycle last word
    applyStimulus(1, 0, 0, '0, '0);
    checkOutput("restart cpu_rst", 32'(cpu_rst), 32'd1);
    checkOutput("restart word_count", 32'(word_count), 32'd0);
    checkOutput("restart ovf_err", 32'(ovf_err), 32'd0);
    applyStimulus(0, 1, 0, 16'hB001, '0);
    applyStimulus(0, 1, 0, 16'hB002, '0);
    applyStimulus(1, 1, 1, 16'hC0FF, '0);
    checkOutput("restart2 word_count", 32'(word_count), 32'd0);
    checkOutput("restart2 pending write", 32'(rom_wdata), 32'hB002);
    applyStimulus(0, 1, 1, 16'hD001, '0);
    checkOutput("restart2 write addr", 32'(rom_addr), 32'd0);
    checkOutput("restart2 write data", 32'(rom_wdata), 32'hD001);
    applyStimulus(0, 0, 0, '0, '0);

    // randomized loads with gaps, overflow, stray restarts and run-mode traffic
    for (int t = 0; t < 40; t++) begin
      applyStimulus(1, 0, 0, '0, ADDR_W'($urandom));
      n = $urandom_range(1, 7);
      sent = 0;
      while (sent < n) begin
        v  = ($urandom_range(0, 2) != 0);
        ls = ($urandom_range(0, 24) == 0);
        applyStimulus(ls, v, v && (sent == n - 1), DATA_W'($urandom), ADDR_W'($urandom));
        if (v) sent++;
      end
      applyStimulus(0, 0, 0, '0, ADDR_W'($urandom));
      repeat ($urandom_range(3, 6))
        applyStimulus(0, $urandom_range(0, 1) == 1, 0, DATA_W'($urandom), ADDR_W'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
